apb_req_queue: RTL and testbench

Command queue and response collector directly upstream of the APB4 master. Buffers host read/write requests, presents them one at a time on the master's stimulus inputs (`transfer`, `SWRITE`, `SADDR`, `SWDATA`, `SSTRB`, `SPROT`), and watches the bus for completion. On completion it pops the request, returns read data and error status, and keeps a saturating count of slave errors.

---
 rtl/apb_req_queue_pkg.sv | 30 +++
 rtl/apb_req_queue_if.sv | 55 +++++
 rtl/apb_sync_fifo.sv | 54 +++++
 rtl/apb_req_queue.sv | 138 +++++++++++++
 tb/tb_apb_req_queue.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_req_queue_pkg.sv
// Shared types and constants for the APB request queue: FSM states, the queued
// request record and the error-counter ceiling.
package apb_q_pkg;

    localparam int unsigned Q_ADDR_W = 32;
    localparam int unsigned Q_DATA_W = 32;
    localparam int unsigned Q_STRB_W = Q_DATA_W / 8;

    localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } q_state_e;

    typedef struct packed {
        logic                write;
        logic [Q_ADDR_W-1:0] addr;
        logic [Q_DATA_W-1:0] wdata;
        logic [Q_STRB_W-1:0] strb;
        logic [2:0]          prot;
    } q_entry_t;

    // Saturating 8-bit increment used by the slave-error counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == ERR_CNT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/apb_req_queue_if.sv
// Host command, APB master stimulus, bus observation and response signals of
// the request queue, bundled with one modport per side.
interface apb_req_queue_if #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [STRB_W-1:0] cmd_strb;
    logic [2:0]        cmd_prot;

    logic              transfer;
    logic              SWRITE;
    logic [ADDR_W-1:0] SADDR;
    logic [DATA_W-1:0] SWDATA;
    logic [STRB_W-1:0] SSTRB;
    logic [2:0]        SPROT;

    logic              PSEL;
    logic              PENABLE;
    logic              PREADY;
    logic              PSLVERR;
    logic [DATA_W-1:0] PRDATA;

    logic              rsp_valid;
    logic              rsp_write;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [CNT_W-1:0]  count;
    logic [7:0]        err_cnt;

    // The queue itself.
    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        input  PSEL, PENABLE, PREADY, PSLVERR, PRDATA,
        output cmd_ready, transfer, SWRITE, SADDR, SWDATA, SSTRB, SPROT,
        output rsp_valid, rsp_write, rsp_rdata, rsp_err, count, err_cnt
    );

    // Host plus bus side driving the queue.
    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        output PSEL, PENABLE, PREADY, PSLVERR, PRDATA,
        input  cmd_ready, transfer, SWRITE, SADDR, SWDATA, SSTRB, SPROT,
        input  rsp_valid, rsp_write, rsp_rdata, rsp_err, count, err_cnt
    );

endinterface

// File: rtl/apb_sync_fifo.sv
// Synchronous FIFO with registered occupancy, full and empty flags and a
// fall-through head output.
module apb_sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter type         entry_t = logic [7:0],
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  entry_t           wr_data,
    input  logic             pop,
    output entry_t           head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_en;
    logic             rd_en;
    logic [CNT_W-1:0] count_nxt;

    // A full queue refuses pushes even when the head is leaving this cycle.
    assign wr_en     = push & ~full;
    assign rd_en     = pop & ~empty;
    assign count_nxt = count + CNT_W'(wr_en) - CNT_W'(rd_en);
    assign head      = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nxt;
            full  <= (count_nxt == CNT_W'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    // Storage carries no reset; only occupied slots are ever read out.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/apb_req_queue.sv
// Request queue in front of the APB4 master: buffers host requests, issues
// them one at a time, and collects read data and slave-error status.
import apb_q_pkg::*;

module apb_req_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = Q_ADDR_W,
    parameter int unsigned DATA_W = Q_DATA_W
) (
    input logic            PCLK,
    input logic            PRESETn,
    apb_req_queue_if.slave bus
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    q_state_e          st;
    q_entry_t          cmd_entry;
    q_entry_t          head;
    q_entry_t          load_entry;
    q_entry_t          s_q;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic              push;
    logic              pop;
    logic              done;
    logic              issue_nxt;

    logic              transfer_q;
    logic              rsp_valid_q;
    logic              rsp_write_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;
    logic [7:0]        err_cnt_q;

    assign cmd_entry = '{
        write: bus.cmd_write,
        addr:  Q_ADDR_W'(bus.cmd_addr),
        wdata: Q_DATA_W'(bus.cmd_wdata),
        strb:  Q_STRB_W'(bus.cmd_strb),
        prot:  bus.cmd_prot
    };

    assign push = bus.cmd_valid & ~full;
    assign done = bus.PSEL & bus.PENABLE & bus.PREADY;
    assign pop  = (st == ISSUE) & done;

    // Outside ISSUE nothing pops, so the queue is non-empty next cycle iff it is
    // non-empty now or a push lands; an empty queue issues the incoming request.
    assign issue_nxt  = push | ~empty;
    assign load_entry = empty ? cmd_entry : head;

    apb_sync_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (q_entry_t)
    ) u_fifo (
        .clk     (PCLK),
        .rst_n   (PRESETn),
        .push    (push),
        .wr_data (cmd_entry),
        .pop     (pop),
        .head    (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    // Issue FSM with registered master stimulus and response capture.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            st          <= IDLE;
            transfer_q  <= 1'b0;
            s_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            rsp_valid_q <= 1'b0;

            case (st)
                IDLE: begin
                    if (issue_nxt) begin
                        st         <= ISSUE;
                        transfer_q <= 1'b1;
                        s_q        <= load_entry;
                    end
                end
                ISSUE: begin
                    if (done) begin
                        st         <= GAP;
                        transfer_q <= 1'b0;
                    end
                end
                GAP: begin
                    if (issue_nxt) begin
                        st         <= ISSUE;
                        transfer_q <= 1'b1;
                        s_q        <= load_entry;
                    end else begin
                        st         <= IDLE;
                        transfer_q <= 1'b0;
                    end
                end
                default: begin
                    st         <= IDLE;
                    transfer_q <= 1'b0;
                end
            endcase

            if (pop) begin
                rsp_valid_q <= 1'b1;
                rsp_write_q <= s_q.write;
                rsp_err_q   <= bus.PSLVERR;
                rsp_rdata_q <= s_q.write ? '0 : bus.PRDATA;
                if (bus.PSLVERR) err_cnt_q <= sat_inc8(err_cnt_q);
            end
        end
    end

    assign bus.cmd_ready = ~full;
    assign bus.count     = count;
    assign bus.transfer  = transfer_q;
    assign bus.SWRITE    = s_q.write;
    assign bus.SADDR     = ADDR_W'(s_q.addr);
    assign bus.SWDATA    = DATA_W'(s_q.wdata);
    assign bus.SSTRB     = STRB_W'(s_q.strb);
    assign bus.SPROT     = s_q.prot;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_write = rsp_write_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_apb_req_queue.sv
// Directed bench for apb_req_queue: a small APB master/slave model answers
// issued requests, and a scoreboard checks issue fields and responses in order.
module tb_apb_req_queue;

    localparam int unsigned DEPTH = 4;

    logic PCLK;
    logic PRESETn;

    apb_req_queue_if #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) bus ();

    apb_req_queue #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus.slave)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          rsp_seen = 0;
    int unsigned exp_err_cnt = 0;
    logic        pend_chk = 1'b0;

    int unsigned ws_cfg = 0;
    logic        err_cfg = 1'b0;

    function automatic logic [31:0] slv_data(input logic [31:0] a);
        if (a == 32'h20) return 32'hDEADBEEF;
        return {a[15:0] ^ 16'hC3C3, a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // APB master + slave model: SETUP, ACCESS with ws_cfg wait states, back to idle.
    typedef enum logic [1:0] {M_IDLE, M_SETUP, M_ACCESS} m_state_e;
    m_state_e    mst;
    int unsigned acc_cnt;
    logic [31:0] m_addr;

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            mst     <= M_IDLE;
            acc_cnt <= 0;
            m_addr  <= '0;
        end else begin
            case (mst)
                M_IDLE:   if (bus.transfer) begin mst <= M_SETUP; m_addr <= bus.SADDR; end
                M_SETUP:  begin mst <= M_ACCESS; acc_cnt <= 0; end
                M_ACCESS: if (bus.PREADY) mst <= M_IDLE; else acc_cnt <= acc_cnt + 1;
                default:  mst <= M_IDLE;
            endcase
        end
    end

    assign bus.PSEL    = (mst != M_IDLE);
    assign bus.PENABLE = (mst == M_ACCESS);
    assign bus.PREADY  = (mst == M_ACCESS) && (acc_cnt >= ws_cfg);
    assign bus.PSLVERR = bus.PREADY & err_cfg;
    assign bus.PRDATA  = bus.PREADY ? slv_data(m_addr) : 32'h0;

    // Monitor: issue fields vs scoreboard head, responses popped in order.
    always @(negedge PCLK) begin
        if (!PRESETn) begin
            pend_chk    = 1'b0;
            exp_err_cnt = 0;
        end else begin
            if (pend_chk) check("issue_after_gap", 64'(bus.transfer), 64'(1));
            pend_chk = 1'b0;
            if (bus.rsp_valid) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 64'(bus.rsp_valid), 64'(0));
                end else begin
                    mon_e = sb.pop_front();
                    rsp_seen++;
                    if (mon_e.err && exp_err_cnt < 255) exp_err_cnt++;
                    check("rsp_write", 64'(bus.rsp_write), 64'(mon_e.write));
                    check("rsp_rdata", 64'(bus.rsp_rdata), 64'(mon_e.rdata));
                    check("rsp_err",   64'(bus.rsp_err),   64'(mon_e.err));
                    check("err_cnt",   64'(bus.err_cnt),   64'(exp_err_cnt));
                    check("gap_transfer", 64'(bus.transfer), 64'(0));
                    pend_chk = (sb.size() != 0);
                end
            end else if (bus.transfer) begin
                if (sb.size() == 0) begin
                    check("spurious_transfer", 64'(bus.transfer), 64'(0));
                end else begin
                    check("SWRITE", 64'(bus.SWRITE), 64'(sb[0].write));
                    check("SADDR",  64'(bus.SADDR),  64'(sb[0].addr));
                    check("SWDATA", 64'(bus.SWDATA), 64'(sb[0].wdata));
                    check("SSTRB",  64'(bus.SSTRB),  64'(sb[0].strb));
                    check("SPROT",  64'(bus.SPROT),  64'(sb[0].prot));
                end
            end
        end
    end

    task automatic do_push(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [2:0] p);
        int   n;
        exp_t e;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        bus.cmd_strb  = s;
        bus.cmd_prot  = p;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 400) begin
            @(posedge PCLK); #1;
            n++;
        end
        if (n >= 400) begin
            check("push_timeout", 64'(bus.cmd_ready), 64'(1));
            bus.cmd_valid = 1'b0;
            return;
        end
        @(posedge PCLK);
        e.write = w; e.addr = a; e.wdata = d; e.strb = s; e.prot = p;
        e.rdata = w ? 32'h0 : slv_data(a);
        e.err   = err_cfg;
        sb.push_back(e);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(posedge PCLK); #1;
            n++;
        end
        if (n >= 3000) check("drain_timeout", 64'(sb.size()), 64'(0));
        repeat (2) begin @(posedge PCLK); #1; end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;

        PRESETn       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_strb  = '0;
        bus.cmd_prot  = '0;
        repeat (3) @(posedge PCLK);
        #1;

        // Reset state.
        check("rst_transfer",  64'(bus.transfer),  64'(0));
        check("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
        check("rst_count",     64'(bus.count),     64'(0));
        check("rst_err_cnt",   64'(bus.err_cnt),   64'(0));
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("rst_rsp_write", 64'(bus.rsp_write), 64'(0));
        check("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'(0));
        check("rst_rsp_err",   64'(bus.rsp_err),   64'(0));
        check("rst_SADDR",     64'(bus.SADDR),     64'(0));
        check("rst_SWDATA",    64'(bus.SWDATA),    64'(0));
        check("rst_SWRITE",    64'(bus.SWRITE),    64'(0));
        PRESETn = 1'b1;
        @(posedge PCLK); #1;

        // Single write, slave ready on the first access cycle.
        ws_cfg = 0; err_cfg = 1'b0;
        do_push(1'b1, 32'h10, 32'hA5A5A5A5, 4'hF, 3'd0);
        check("wr_transfer_n1", 64'(bus.transfer), 64'(1));
        check("wr_SADDR_n1",    64'(bus.SADDR),    64'(32'h10));
        check("wr_count",       64'(bus.count),    64'(1));
        wait_drain();
        check("wr_count_after", 64'(bus.count),    64'(0));

        // Read with three wait states.
        ws_cfg = 3;
        do_push(1'b0, 32'h20, 32'h0, 4'hF, 3'd2);
        wait_drain();
        check("rd_rsp_valid_clear", 64'(bus.rsp_valid), 64'(0));
        check("rd_last_rdata",      64'(bus.rsp_rdata), 64'(32'hDEADBEEF));

        // Full queue with a stalled slave.
        ws_cfg = 20;
        base = rsp_seen;
        for (int i = 0; i < 4; i++)
            do_push(i[0], 32'h100 + 32'(i * 4), 32'h1000 + 32'(i), 4'hF, 3'(i));
        check("full_count",     64'(bus.count),     64'(DEPTH));
        check("full_cmd_ready", 64'(bus.cmd_ready), 64'(0));
        do_push(1'b0, 32'h110, 32'h0, 4'h3, 3'd5);
        check("full_held_until_done", 64'(rsp_seen), 64'(base + 1));
        ws_cfg = 0;
        wait_drain();
        check("full_all_rsp", 64'(rsp_seen), 64'(base + 5));

        // Error counter saturation.
        err_cfg = 1'b1;
        for (int i = 0; i < 260; i++)
            do_push(1'b1, 32'h200 + 32'(i * 4), 32'(i), 4'(i), 3'(i));
        wait_drain();
        check("err_cnt_sat", 64'(bus.err_cnt), 64'(255));
        err_cfg = 1'b0;

        // Reset during an ACCESS phase with three entries queued.
        ws_cfg = 20;
        for (int i = 0; i < 3; i++)
            do_push(1'b1, 32'h300 + 32'(i * 4), 32'h3000 + 32'(i), 4'hF, 3'd1);
        n = 0;
        while (mst != M_ACCESS && n < 50) begin @(posedge PCLK); #1; n++; end
        if (n >= 50) check("access_timeout", 64'(mst == M_ACCESS), 64'(1));
        PRESETn = 1'b0;
        sb.delete();
        @(posedge PCLK); #1;
        check("mid_rst_transfer",  64'(bus.transfer),  64'(0));
        check("mid_rst_count",     64'(bus.count),     64'(0));
        check("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("mid_rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
        check("mid_rst_err_cnt",   64'(bus.err_cnt),   64'(0));
        check("mid_rst_SADDR",     64'(bus.SADDR),     64'(0));
        PRESETn = 1'b1;
        ws_cfg = 0;
        @(posedge PCLK); #1;
        do_push(1'b0, 32'h20, 32'h0, 4'hF, 3'd3);
        check("post_rst_transfer", 64'(bus.transfer), 64'(1));
        check("post_rst_SADDR",    64'(bus.SADDR),    64'(32'h20));
        do_push(1'b1, 32'h44, 32'h12345678, 4'h5, 3'd6);
        wait_drain();
        check("post_rst_count", 64'(bus.count), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
